// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge port.
// Master drives the request; slave acknowledges and returns read data.
interface mem_access_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ack, rdata
    );
endinterface

// File: rtl/mem_access.sv
// Memory stage: load/store to dmem request/ack transactions,
// byte-lane formatting, load extension, and writeback registers.
module mem_access #(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_in,
    input  logic [3:0]   op_type_in,
    input  logic [4:0]   op_spec_in,
    input  logic [4:0]   rd_ind_in,
    input  logic [31:0]  rd_dat_in,
    input  logic [31:0]  mem_addr_in,
    input  logic [31:0]  mem_dat_in,
    input  logic         mem_read_en,
    input  logic         mem_write_en,
    input  logic         flsh,
    output logic         stall_out,
    mem_access_if.master dmem,
    output logic         valid_out,
    output logic [3:0]   op_type_out,
    output logic [4:0]   op_spec_out,
    output logic [4:0]   rd_ind_out,
    output logic [31:0]  rd_dat_out,
    output logic [1:0]   exc_out
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(ACK_TIMEOUT);

    state_t           state, state_nxt;
    logic [31:0]      addr_q, dat_q;
    logic [4:0]       spec_q, rd_q;
    logic [3:0]       type_q;
    logic             we_q, kill_q, kill_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;

    logic        mem_op, half_op, word_op, misal;
    logic        busy, tmo, req, stall, cap;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_v, wdata_v;
    logic [3:0]  be_v;

    logic        v_n;
    logic [3:0]  t_n;
    logic [4:0]  s_n, r_n;
    logic [31:0] d_n;
    logic [1:0]  e_n;

    assign mem_op  = valid_in & (mem_read_en | mem_write_en);
    assign half_op = (op_spec_in == 5'd1) | (op_spec_in == 5'd4)
                   | (op_spec_in == 5'd6);
    assign word_op = (op_spec_in == 5'd2) | (op_spec_in == 5'd7);
    assign misal   = (half_op & mem_addr_in[0])
                   | (word_op & (|mem_addr_in[1:0]));

    assign busy = (state == BUSY);
    assign tmo  = busy && (ACK_TIMEOUT != 0) && (cnt_q == TMO);

    // Store lane formatting and load extraction from the captured op.
    always_comb begin
        byte_v  = 8'(dmem.rdata >> {addr_q[1:0], 3'b000});
        half_v  = 16'(dmem.rdata >> {addr_q[1], 4'b0000});
        be_v    = 4'hF;
        wdata_v = dat_q;
        load_v  = dmem.rdata;
        if (we_q) begin
            if (spec_q == 5'd5) begin
                be_v    = 4'b0001 << addr_q[1:0];
                wdata_v = {4{dat_q[7:0]}};
            end else if (spec_q == 5'd6) begin
                be_v    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_v = {2{dat_q[15:0]}};
            end
        end
        case (spec_q)
            5'd0:    load_v = {{24{byte_v[7]}}, byte_v};
            5'd1:    load_v = {{16{half_v[15]}}, half_v};
            5'd3:    load_v = {24'h0, byte_v};
            5'd4:    load_v = {16'h0, half_v};
            default: load_v = dmem.rdata;
        endcase
    end

    // Next state, handshake outputs and next writeback values.
    always_comb begin
        state_nxt = state;
        kill_nxt  = kill_q;
        cnt_nxt   = cnt_q;
        cap       = 1'b0;
        req       = 1'b0;
        stall     = 1'b0;
        v_n       = 1'b0;
        t_n       = 4'h0;
        s_n       = 5'h0;
        r_n       = 5'h0;
        d_n       = 32'h0;
        e_n       = 2'b00;
        unique case (state)
            IDLE: begin
                kill_nxt = 1'b0;
                cnt_nxt  = '0;
                if (valid_in && !flsh) begin
                    if (mem_op && !misal) begin
                        stall     = 1'b1;
                        cap       = 1'b1;
                        state_nxt = BUSY;
                    end else begin
                        v_n = 1'b1;
                        t_n = op_type_in;
                        s_n = op_spec_in;
                        r_n = rd_ind_in;
                        d_n = mem_op ? 32'h0 : rd_dat_in;
                        e_n = mem_op ? 2'b01 : 2'b00;
                    end
                end
            end
            BUSY: begin
                req   = ~tmo;
                stall = ~tmo & ~dmem.ack;
                if (flsh) kill_nxt = 1'b1;
                if (!tmo && !dmem.ack) cnt_nxt = cnt_q + 1'b1;
                if (tmo || dmem.ack) begin
                    state_nxt = IDLE;
                    if (!(kill_q || flsh)) begin
                        v_n = 1'b1;
                        t_n = type_q;
                        s_n = spec_q;
                        r_n = rd_q;
                        d_n = (tmo || we_q) ? 32'h0 : load_v;
                        e_n = tmo ? 2'b10 : 2'b00;
                    end
                end
            end
        endcase
    end

    assign stall_out   = stall;
    assign dmem.req    = req;
    assign dmem.we     = req & we_q;
    assign dmem.addr   = req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign dmem.wdata  = req ? wdata_v : 32'h0;
    assign dmem.be     = req ? be_v : 4'h0;

    // State, wait counter, kill flag and captured transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt_q  <= '0;
            kill_q <= 1'b0;
            addr_q <= 32'h0;
            dat_q  <= 32'h0;
            spec_q <= 5'h0;
            rd_q   <= 5'h0;
            type_q <= 4'h0;
            we_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt_q  <= cnt_nxt;
            kill_q <= kill_nxt;
            if (cap) begin
                addr_q <= mem_addr_in;
                dat_q  <= mem_dat_in;
                spec_q <= op_spec_in;
                rd_q   <= rd_ind_in;
                type_q <= op_type_in;
                we_q   <= mem_write_en;
            end
        end
    end

    // Writeback registers, rewritten every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out   <= 1'b0;
            op_type_out <= 4'h0;
            op_spec_out <= 5'h0;
            rd_ind_out  <= 5'h0;
            rd_dat_out  <= 32'h0;
            exc_out     <= 2'b00;
        end else begin
            valid_out   <= v_n;
            op_type_out <= t_n;
            op_spec_out <= s_n;
            rd_ind_out  <= r_n;
            rd_dat_out  <= d_n;
            exc_out     <= e_n;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, misalignment,
// timeout, flush, passthrough and reset during a transaction.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in;
    logic [3:0]  op_type_in;
    logic [4:0]  op_spec_in;
    logic [4:0]  rd_ind_in;
    logic [31:0] rd_dat_in;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_dat_in;
    logic        mem_read_en;
    logic        mem_write_en;
    logic        flsh;
    logic        stall_out;
    logic        valid_out;
    logic [3:0]  op_type_out;
    logic [4:0]  op_spec_out;
    logic [4:0]  rd_ind_out;
    logic [31:0] rd_dat_out;
    logic [1:0]  exc_out;

    int vecs = 0;
    int errs = 0;

    mem_access_if bus ();

    mem_access #(.ACK_TIMEOUT(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_in     (valid_in),
        .op_type_in   (op_type_in),
        .op_spec_in   (op_spec_in),
        .rd_ind_in    (rd_ind_in),
        .rd_dat_in    (rd_dat_in),
        .mem_addr_in  (mem_addr_in),
        .mem_dat_in   (mem_dat_in),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .flsh         (flsh),
        .stall_out    (stall_out),
        .dmem         (bus),
        .valid_out    (valid_out),
        .op_type_out  (op_type_out),
        .op_spec_out  (op_spec_out),
        .rd_ind_out   (rd_ind_out),
        .rd_dat_out   (rd_dat_out),
        .exc_out      (exc_out)
    );

    always #5 clk = ~clk;

    // Load extension table: spec, addr, expected result for rdata 0x80FF1234
    logic [4:0]  ld_spec [6] = '{5'd0, 5'd3, 5'd1, 5'd4, 5'd1, 5'd0};
    logic [31:0] ld_addr [6] = '{32'h103, 32'h103, 32'h102,
                                 32'h100, 32'h100, 32'h101};
    logic [31:0] ld_exp  [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                                 32'h00001234, 32'h00001234, 32'h00000012};

    // Store table: spec, addr, data, expected be / wdata / word addr
    logic [4:0]  st_spec [3] = '{5'd6, 5'd5, 5'd7};
    logic [31:0] st_addr [3] = '{32'h202, 32'h201, 32'h204};
    logic [31:0] st_dat  [3] = '{32'h0000ABCD, 32'h0000005A, 32'h12345678};
    logic [3:0]  st_be   [3] = '{4'b1100, 4'b0010, 4'hF};
    logic [31:0] st_wd   [3] = '{32'hABCDABCD, 32'h5A5A5A5A, 32'h12345678};
    logic [31:0] st_wa   [3] = '{32'h200, 32'h200, 32'h204};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clr;
        valid_in     = 1'b0;
        op_type_in   = 4'h0;
        op_spec_in   = 5'h0;
        rd_ind_in    = 5'h0;
        rd_dat_in    = 32'h0;
        mem_addr_in  = 32'h0;
        mem_dat_in   = 32'h0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        flsh         = 1'b0;
        bus.ack      = 1'b0;
        bus.rdata    = 32'h0;
    endtask

    task automatic put(input logic [4:0] spec, input logic [31:0] addr,
                       input logic [31:0] dat, input logic we,
                       input logic [4:0] rd);
        valid_in     = 1'b1;
        op_type_in   = 4'b0001;
        op_spec_in   = spec;
        rd_ind_in    = rd;
        rd_dat_in    = 32'h0;
        mem_addr_in  = addr;
        mem_dat_in   = dat;
        mem_read_en  = ~we;
        mem_write_en = we;
    endtask

    task automatic test_reset;
        clr();
        #12;
        vecs++; if (stall_out !== 1'b0) begin errs++; $display("FAIL rst_stall got %0b exp 0", stall_out); end
        vecs++; if (bus.req !== 1'b0) begin errs++; $display("FAIL rst_req got %0b exp 0", bus.req); end
        vecs++; if (valid_out !== 1'b0) begin errs++; $display("FAIL rst_valid got %0b exp 0", valid_out); end
        vecs++; if (rd_dat_out !== 32'h0) begin errs++; $display("FAIL rst_rd_dat got %h exp 0", rd_dat_out); end
        vecs++; if (exc_out !== 2'b00) begin errs++; $display("FAIL rst_exc got %b exp 00", exc_out); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_lw;
        int st;
        st = 0;
        step();
        put(5'd2, 32'h100, 32'h0, 1'b0, 5'd3);
        @(negedge clk);
        st += int'(stall_out);
        vecs++; if (bus.req !== 1'b0) begin errs++; $display("FAIL lw_req_acc got %0b exp 0", bus.req); end
        step();
        @(negedge clk);
        st += int'(stall_out);
        vecs++; if (bus.req !== 1'b1) begin errs++; $display("FAIL lw_req got %0b exp 1", bus.req); end
        vecs++; if (bus.addr !== 32'h100) begin errs++; $display("FAIL lw_addr got %h exp 100", bus.addr); end
        vecs++; if (bus.be !== 4'hF) begin errs++; $display("FAIL lw_be got %h exp f", bus.be); end
        vecs++; if (bus.we !== 1'b0) begin errs++; $display("FAIL lw_we got %0b exp 0", bus.we); end
        step();
        @(negedge clk);
        st += int'(stall_out);
        step();
        bus.ack   = 1'b1;
        bus.rdata = 32'hDEADBEEF;
        @(negedge clk);
        st += int'(stall_out);
        vecs++; if (bus.req !== 1'b1) begin errs++; $display("FAIL lw_req_ack got %0b exp 1", bus.req); end
        step();
        clr();
        @(negedge clk);
        vecs++; if (st != 3) begin errs++; $display("FAIL lw_stall_cycles got %0d exp 3", st); end
        vecs++; if (valid_out !== 1'b1) begin errs++; $display("FAIL lw_valid got %0b exp 1", valid_out); end
        vecs++; if (rd_dat_out !== 32'hDEADBEEF) begin errs++; $display("FAIL lw_data got %h exp deadbeef", rd_dat_out); end
        vecs++; if (rd_ind_out !== 5'd3) begin errs++; $display("FAIL lw_rd got %0d exp 3", rd_ind_out); end
        vecs++; if (exc_out !== 2'b00) begin errs++; $display("FAIL lw_exc got %b exp 00", exc_out); end
        step();
        @(negedge clk);
        vecs++; if (valid_out !== 1'b0) begin errs++; $display("FAIL lw_valid_after got %0b exp 0", valid_out); end
    endtask

    task automatic test_load_ext;
        for (int i = 0; i < 6; i++) begin
            step();
            put(ld_spec[i], ld_addr[i], 32'h0, 1'b0, 5'd4);
            step();
            bus.ack   = 1'b1;
            bus.rdata = 32'h80FF1234;
            step();
            clr();
            @(negedge clk);
            vecs++; if (valid_out !== 1'b1) begin errs++; $display("FAIL ld%0d_valid got %0b exp 1", i, valid_out); end
            vecs++; if (rd_dat_out !== ld_exp[i]) begin errs++; $display("FAIL ld%0d_data got %h exp %h", i, rd_dat_out, ld_exp[i]); end
        end
    endtask

    task automatic test_store;
        for (int i = 0; i < 3; i++) begin
            step();
            put(st_spec[i], st_addr[i], st_dat[i], 1'b1, 5'd0);
            step();
            bus.ack = 1'b1;
            @(negedge clk);
            vecs++; if (bus.we !== 1'b1) begin errs++; $display("FAIL st%0d_we got %0b exp 1", i, bus.we); end
            vecs++; if (bus.be !== st_be[i]) begin errs++; $display("FAIL st%0d_be got %b exp %b", i, bus.be, st_be[i]); end
            vecs++; if (bus.wdata !== st_wd[i]) begin errs++; $display("FAIL st%0d_wdata got %h exp %h", i, bus.wdata, st_wd[i]); end
            vecs++; if (bus.addr !== st_wa[i]) begin errs++; $display("FAIL st%0d_addr got %h exp %h", i, bus.addr, st_wa[i]); end
            vecs++; if (stall_out !== 1'b0) begin errs++; $display("FAIL st%0d_stall got %0b exp 0", i, stall_out); end
            step();
            clr();
            @(negedge clk);
            vecs++; if (valid_out !== 1'b1) begin errs++; $display("FAIL st%0d_valid got %0b exp 1", i, valid_out); end
            vecs++; if (rd_dat_out !== 32'h0) begin errs++; $display("FAIL st%0d_data got %h exp 0", i, rd_dat_out); end
        end
    endtask

    task automatic test_back_to_back;
        step();
        put(5'd2, 32'h500, 32'h0, 1'b0, 5'd9);
        step();
        bus.ack   = 1'b1;
        bus.rdata = 32'h11223344;
        step();
        bus.ack = 1'b0;
        put(5'd7, 32'h504, 32'hCAFE0000, 1'b1, 5'd0);
        @(negedge clk);
        vecs++; if (valid_out !== 1'b1) begin errs++; $display("FAIL b2b_valid got %0b exp 1", valid_out); end
        vecs++; if (rd_dat_out !== 32'h11223344) begin errs++; $display("FAIL b2b_data got %h exp 11223344", rd_dat_out); end
        vecs++; if (stall_out !== 1'b1) begin errs++; $display("FAIL b2b_stall got %0b exp 1", stall_out); end
        step();
        bus.ack = 1'b1;
        @(negedge clk);
        vecs++; if (bus.wdata !== 32'hCAFE0000) begin errs++; $display("FAIL b2b_wdata got %h exp cafe0000", bus.wdata); end
        vecs++; if (bus.addr !== 32'h504) begin errs++; $display("FAIL b2b_addr got %h exp 504", bus.addr); end
        step();
        clr();
        @(negedge clk);
        vecs++; if (valid_out !== 1'b1) begin errs++; $display("FAIL b2b_st_valid got %0b exp 1", valid_out); end
        vecs++; if (op_spec_out !== 5'd7) begin errs++; $display("FAIL b2b_st_spec got %0d exp 7", op_spec_out); end
    endtask

    task automatic test_misaligned;
        step();
        put(5'd2, 32'h101, 32'h0, 1'b0, 5'd6);
        @(negedge clk);
        vecs++; if (stall_out !== 1'b0) begin errs++; $display("FAIL mis_lw_stall got %0b exp 0", stall_out); end
        step();
        put(5'd6, 32'h203, 32'h1234, 1'b1, 5'd0);
        @(negedge clk);
        vecs++; if (bus.req !== 1'b0) begin errs++; $display("FAIL mis_lw_req got %0b exp 0", bus.req); end
        vecs++; if (valid_out !== 1'b1) begin errs++; $display("FAIL mis_lw_valid got %0b exp 1", valid_out); end
        vecs++; if (exc_out !== 2'b01) begin errs++; $display("FAIL mis_lw_exc got %b exp 01", exc_out); end
        vecs++; if (rd_dat_out !== 32'h0) begin errs++; $display("FAIL mis_lw_data got %h exp 0", rd_dat_out); end
        vecs++; if (rd_ind_out !== 5'd6) begin errs++; $display("FAIL mis_lw_rd got %0d exp 6", rd_ind_out); end
        vecs++; if (stall_out !== 1'b0) begin errs++; $display("FAIL mis_sh_stall got %0b exp 0", stall_out); end
        step();
        clr();
        @(negedge clk);
        vecs++; if (bus.req !== 1'b0) begin errs++; $display("FAIL mis_sh_req got %0b exp 0", bus.req); end
        vecs++; if (exc_out !== 2'b01) begin errs++; $display("FAIL mis_sh_exc got %b exp 01", exc_out); end
    endtask

    task automatic test_timeout;
        int reqs;
        reqs = 0;
        step();
        put(5'd2, 32'h300, 32'h0, 1'b0, 5'd2);
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 6) clr();
            @(negedge clk);
            reqs += int'(bus.req);
            if (k == 5) begin
                vecs++; if (stall_out !== 1'b0) begin errs++; $display("FAIL tmo_stall got %0b exp 0", stall_out); end
            end
            if (k == 6) begin
                vecs++; if (valid_out !== 1'b1) begin errs++; $display("FAIL tmo_valid got %0b exp 1", valid_out); end
                vecs++; if (exc_out !== 2'b10) begin errs++; $display("FAIL tmo_exc got %b exp 10", exc_out); end
                vecs++; if (rd_dat_out !== 32'h0) begin errs++; $display("FAIL tmo_data got %h exp 0", rd_dat_out); end
            end
        end
        vecs++; if (reqs != 4) begin errs++; $display("FAIL tmo_req_cycles got %0d exp 4", reqs); end
    endtask

    task automatic test_flush;
        step();
        put(5'd2, 32'h400, 32'h0, 1'b0, 5'd8);
        step();
        flsh = 1'b1;
        @(negedge clk);
        vecs++; if (bus.req !== 1'b1) begin errs++; $display("FAIL fl_req1 got %0b exp 1", bus.req); end
        step();
        flsh      = 1'b0;
        bus.ack   = 1'b1;
        bus.rdata = 32'h12345678;
        @(negedge clk);
        vecs++; if (bus.req !== 1'b1) begin errs++; $display("FAIL fl_req2 got %0b exp 1", bus.req); end
        step();
        clr();
        @(negedge clk);
        vecs++; if (valid_out !== 1'b0) begin errs++; $display("FAIL fl_valid got %0b exp 0", valid_out); end
        vecs++; if (rd_dat_out !== 32'h0) begin errs++; $display("FAIL fl_data got %h exp 0", rd_dat_out); end
        step();
        put(5'd2, 32'h404, 32'h0, 1'b0, 5'd8);
        flsh = 1'b1;
        @(negedge clk);
        vecs++; if (stall_out !== 1'b0) begin errs++; $display("FAIL fl_idle_stall got %0b exp 0", stall_out); end
        step();
        clr();
        @(negedge clk);
        vecs++; if (bus.req !== 1'b0) begin errs++; $display("FAIL fl_idle_req got %0b exp 0", bus.req); end
        vecs++; if (valid_out !== 1'b0) begin errs++; $display("FAIL fl_idle_valid got %0b exp 0", valid_out); end
    endtask

    task automatic test_pass_reset;
        step();
        valid_in   = 1'b1;
        op_type_in = 4'b0010;
        rd_ind_in  = 5'd7;
        rd_dat_in  = 32'h5;
        @(negedge clk);
        vecs++; if (stall_out !== 1'b0) begin errs++; $display("FAIL pt_stall got %0b exp 0", stall_out); end
        step();
        clr();
        @(negedge clk);
        vecs++; if (valid_out !== 1'b1) begin errs++; $display("FAIL pt_valid got %0b exp 1", valid_out); end
        vecs++; if (rd_dat_out !== 32'h5) begin errs++; $display("FAIL pt_data got %h exp 5", rd_dat_out); end
        vecs++; if (rd_ind_out !== 5'd7) begin errs++; $display("FAIL pt_rd got %0d exp 7", rd_ind_out); end
        vecs++; if (op_type_out !== 4'b0010) begin errs++; $display("FAIL pt_type got %b exp 0010", op_type_out); end
        step();
        put(5'd2, 32'h600, 32'h0, 1'b0, 5'd1);
        step();
        @(negedge clk);
        vecs++; if (bus.req !== 1'b1) begin errs++; $display("FAIL rb_req_pre got %0b exp 1", bus.req); end
        #2;
        clr();
        rst_n = 1'b0;
        #1;
        vecs++; if (bus.req !== 1'b0) begin errs++; $display("FAIL rb_req got %0b exp 0", bus.req); end
        vecs++; if (stall_out !== 1'b0) begin errs++; $display("FAIL rb_stall got %0b exp 0", stall_out); end
        vecs++; if (valid_out !== 1'b0) begin errs++; $display("FAIL rb_valid got %0b exp 0", valid_out); end
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        vecs++; if (bus.req !== 1'b0) begin errs++; $display("FAIL rb_abandon got %0b exp 0", bus.req); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_back_to_back();
        test_misaligned();
        test_timeout();
        test_flush();
        test_pass_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
